md5_multilane_cruncher: RTL
===========================

Name: md5_multilane_cruncher

Overview:
Parametrised multi-lane MD5 compression engine. It runs the 64-round compression for LANES independent 512-bit chunks in lock-step, one round per clock. Each lane has its own message buffer and chaining state. The block sits between the message padder/scheduler and the digest collector, and replaces the single-lane, 4-cycle-per-round cruncher where throughput matters.

Parameters:
LANES, 4, number of parallel hash lanes (1..8)
INITA, 32'h67452301, chaining IV word A
INITB, 32'hefcdab89, chaining IV word B
INITC, 32'h98badcfe, chaining IV word C
INITD, 32'h10325476, chaining IV word D

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
msg_we  in  1  message word write strobe
msg_lane  in  $clog2(LANES) (min 1)  target lane of the write
msg_addr  in  4  word index 0..15 within the chunk
msg_data  in  32  message word, MD5 little-endian word order
msg_err  out  1  one-cycle pulse when a write is rejected
start  in  1  begin compression of the lanes in start_mask
start_mask  in  LANES  lanes that take part in this run
init_mask  in  LANES  lanes whose chain is reloaded with the IV before this run
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the digests are updated
digest  out  LANES*128  per-lane {d0,c0,b0,a0}; lane 0 in bits [127:0]

Behaviour:
- Reset: all lane chains set to INITA..D; FSM to IDLE; busy=0, done=0, msg_err=0; message buffers are not cleared.
- Reset mid-run aborts the run: chains return to the IV, no done pulse.
- FSM states are IDLE, CRUNCH, FINAL, DONE.
- IDLE, start=1 and start_mask!=0:
  - latch start_mask into run_mask;
  - for each lane with init_mask=1, load a0..d0 with the IV;
  - working regs a,b,c,d for run lanes take the (possibly reloaded) chain;
  - round counter i=0; go to CRUNCH.
- start with start_mask=0: ignored.
- start while busy: ignored; no error pulse.
- init_mask bits outside start_mask: ignored.
- CRUNCH:
  - each cycle, every run lane computes one standard MD5 round using shared K[i], s[i], g(i) and F/G/H/I selected by i[5:4];
  - new a=d, b=b+rotl(a+F+K+M[g],s), c=b, d=c; all sums mod 2^32;
  - i increments; after i=63 go to FINAL (64 cycles).
- FINAL: each run lane adds in parallel (a0+=a, b0+=b, c0+=c, d0+=d, mod 2^32); go to DONE.
- DONE: done=1 for exactly one cycle; busy falls in the same cycle; return to IDLE.
- Latency: start accepted at cycle 0 → done high at cycle 66; the next start is accepted in the cycle after done.
- Lanes not in run_mask hold their chains and digests unchanged for the whole run.
- digest is driven directly from the chain regs. It is stable except in the FINAL→DONE update edge and at an accepted start with init_mask set.
- msg_we in IDLE: write buffer[msg_lane][msg_addr].
- msg_we while busy: write dropped, msg_err pulses the next cycle.
- msg_we with msg_lane>=LANES: write dropped, msg_err pulses the next cycle.
- msg_we and start in the same IDLE cycle: the write lands first, so the run uses the new word.

Decomposition:
- Package md5_pkg:
  - IV constants;
  - K table (64×32) and S table (64×5) as constant functions;
  - g-index function;
  - round-function select enum (F_SEL, G_SEL, H_SEL, I_SEL);
  - lane state struct {a,b,c,d}.
- Sub-module md5_round_lane, generated LANES times:
  - purely combinational single round;
  - inputs a,b,c,d, K, s, M[g], sel; outputs next a,b,c,d.
- The top module holds the FSM, counter, buffers and chains.

Test Plan:
- Empty string in lane 0: word0=32'h00000080, rest 0, start_mask=1, init_mask=1 → done at cycle 66; digest[127:0] a0=d98c1dd4, b0=04b2008f, c0=980980e9, d0=7e42f8ec.
- "abc" in lane 1, empty in lane 0 (word0 of lane 1 = 80636261, word14 = 00000018), masks 4'b0011 → lane 1 a0=98500190, b0=b04fd23c, c0=7d3f96d6, d0=727fe128; lane 0 as above; lanes 2–3 still at the IV.
- Chaining: rerun lane 0 with init_mask=0 on the same empty-string chunk → lane 0 a0 equals the reference-model second-block chain; lane 1 unchanged.
- msg_we during busy, and msg_lane=LANES (when LANES<2^width) → msg_err pulse; buffer contents unchanged, confirmed by a repeat hash.
- start pulsed at cycles 10 and 40 of a run → ignored; a single done at cycle 66; busy low the following cycle.
- Reset asserted at cycle 30 of a run → busy=0, no done, all digests equal the IV; a fresh "abc" run then gives the correct digest.

Source files
------------

// File: rtl/md5_pkg.sv
// Shared MD5 constants, per-round tables and lane state for the multi-lane cruncher.
package md5_pkg;

  localparam logic [31:0] MD5_IV_A = 32'h67452301;
  localparam logic [31:0] MD5_IV_B = 32'hefcdab89;
  localparam logic [31:0] MD5_IV_C = 32'h98badcfe;
  localparam logic [31:0] MD5_IV_D = 32'h10325476;

  typedef enum logic [1:0] {F_SEL, G_SEL, H_SEL, I_SEL} rnd_sel_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
  } lane_state_t;

  function automatic logic [31:0] md5_k(input logic [5:0] i);
    case (i)
      6'd0:  return 32'hd76aa478; 6'd1:  return 32'he8c7b756; 6'd2:  return 32'h242070db; 6'd3:  return 32'hc1bdceee;
      6'd4:  return 32'hf57c0faf; 6'd5:  return 32'h4787c62a; 6'd6:  return 32'ha8304613; 6'd7:  return 32'hfd469501;
      6'd8:  return 32'h698098d8; 6'd9:  return 32'h8b44f7af; 6'd10: return 32'hffff5bb1; 6'd11: return 32'h895cd7be;
      6'd12: return 32'h6b901122; 6'd13: return 32'hfd987193; 6'd14: return 32'ha679438e; 6'd15: return 32'h49b40821;
      6'd16: return 32'hf61e2562; 6'd17: return 32'hc040b340; 6'd18: return 32'h265e5a51; 6'd19: return 32'he9b6c7aa;
      6'd20: return 32'hd62f105d; 6'd21: return 32'h02441453; 6'd22: return 32'hd8a1e681; 6'd23: return 32'he7d3fbc8;
      6'd24: return 32'h21e1cde6; 6'd25: return 32'hc33707d6; 6'd26: return 32'hf4d50d87; 6'd27: return 32'h455a14ed;
      6'd28: return 32'ha9e3e905; 6'd29: return 32'hfcefa3f8; 6'd30: return 32'h676f02d9; 6'd31: return 32'h8d2a4c8a;
      6'd32: return 32'hfffa3942; 6'd33: return 32'h8771f681; 6'd34: return 32'h6d9d6122; 6'd35: return 32'hfde5380c;
      6'd36: return 32'ha4beea44; 6'd37: return 32'h4bdecfa9; 6'd38: return 32'hf6bb4b60; 6'd39: return 32'hbebfbc70;
      6'd40: return 32'h289b7ec6; 6'd41: return 32'heaa127fa; 6'd42: return 32'hd4ef3085; 6'd43: return 32'h04881d05;
      6'd44: return 32'hd9d4d039; 6'd45: return 32'he6db99e5; 6'd46: return 32'h1fa27cf8; 6'd47: return 32'hc4ac5665;
      6'd48: return 32'hf4292244; 6'd49: return 32'h432aff97; 6'd50: return 32'hab9423a7; 6'd51: return 32'hfc93a039;
      6'd52: return 32'h655b59c3; 6'd53: return 32'h8f0ccc92; 6'd54: return 32'hffeff47d; 6'd55: return 32'h85845dd1;
      6'd56: return 32'h6fa87e4f; 6'd57: return 32'hfe2ce6e0; 6'd58: return 32'ha3014314; 6'd59: return 32'h4e0811a1;
      6'd60: return 32'hf7537e82; 6'd61: return 32'hbd3af235; 6'd62: return 32'h2ad7d2bb; 6'd63: return 32'heb86d391;
      default: return 32'h0;
    endcase
  endfunction

  // Rotate amounts repeat every four rounds within each 16-round group.
  function automatic logic [4:0] md5_s(input logic [5:0] i);
    case ({i[5:4], i[1:0]})
      4'h0: return 5'd7;  4'h1: return 5'd12; 4'h2: return 5'd17; 4'h3: return 5'd22;
      4'h4: return 5'd5;  4'h5: return 5'd9;  4'h6: return 5'd14; 4'h7: return 5'd20;
      4'h8: return 5'd4;  4'h9: return 5'd11; 4'ha: return 5'd16; 4'hb: return 5'd23;
      4'hc: return 5'd6;  4'hd: return 5'd10; 4'he: return 5'd15; default: return 5'd21;
    endcase
  endfunction

  function automatic logic [3:0] md5_g(input logic [5:0] i);
    case (i[5:4])
      2'd0:    return i[3:0];
      2'd1:    return i[3:0] * 4'd5 + 4'd1;
      2'd2:    return i[3:0] * 4'd3 + 4'd5;
      default: return i[3:0] * 4'd7;
    endcase
  endfunction

endpackage

// File: rtl/md5_round_lane.sv
// One combinational MD5 round for a single lane.
module md5_round_lane
  import md5_pkg::*;
(
  input  lane_state_t cur,
  input  logic [31:0] k,
  input  logic [4:0]  s,
  input  logic [31:0] m,
  input  rnd_sel_t    sel,
  output lane_state_t nxt
);

  logic [31:0] f;
  logic [31:0] t;
  logic [63:0] rot;

  always_comb begin
    f = '0;
    case (sel)
      F_SEL:   f = (cur.b & cur.c) | (~cur.b & cur.d);
      G_SEL:   f = (cur.d & cur.b) | (~cur.d & cur.c);
      H_SEL:   f = cur.b ^ cur.c ^ cur.d;
      default: f = cur.c ^ (cur.b | ~cur.d);
    endcase
    t   = cur.a + f + k + m;
    // upper half of the doubled word shifted left is the left rotation
    rot = {t, t} << s;
    nxt.a = cur.d;
    nxt.b = cur.b + rot[63:32];
    nxt.c = cur.b;
    nxt.d = cur.c;
  end

endmodule

// File: rtl/md5_multilane_cruncher.sv
// Lock-step multi-lane MD5 compression: one round per clock for every lane in the run mask.
module md5_multilane_cruncher
  import md5_pkg::*;
#(
  parameter int          LANES = 4,
  parameter logic [31:0] INITA = MD5_IV_A,
  parameter logic [31:0] INITB = MD5_IV_B,
  parameter logic [31:0] INITC = MD5_IV_C,
  parameter logic [31:0] INITD = MD5_IV_D
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      msg_we,
  input  logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] msg_lane,
  input  logic [3:0]                                msg_addr,
  input  logic [31:0]                               msg_data,
  output logic                                      msg_err,
  input  logic                                      start,
  input  logic [LANES-1:0]                          start_mask,
  input  logic [LANES-1:0]                          init_mask,
  output logic                                      busy,
  output logic                                      done,
  output logic [LANES*128-1:0]                      digest
);

  typedef enum logic [1:0] {IDLE, CRUNCH, FINAL, DONE} state_t;

  localparam lane_state_t IV = '{a: INITA, b: INITB, c: INITC, d: INITD};

  state_t                        state_q, state_d;
  logic [5:0]                    i_q, i_d;
  logic [LANES-1:0]              run_mask_q, run_mask_d;
  lane_state_t [LANES-1:0]       chain_q, chain_d;
  lane_state_t [LANES-1:0]       work_q, work_d;
  lane_state_t [LANES-1:0]       rnd_nxt;
  logic [LANES-1:0][15:0][31:0]  buf_q, buf_d;
  logic                          msg_err_q, msg_err_d;
  logic                          wr_ok;

  logic [31:0] k_cur;
  logic [4:0]  s_cur;
  logic [3:0]  g_cur;
  rnd_sel_t    sel_cur;

  assign k_cur   = md5_k(i_q);
  assign s_cur   = md5_s(i_q);
  assign g_cur   = md5_g(i_q);
  assign sel_cur = rnd_sel_t'(i_q[5:4]);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    md5_round_lane u_round (
      .cur (work_q[l]),
      .k   (k_cur),
      .s   (s_cur),
      .m   (buf_q[l][g_cur]),
      .sel (sel_cur),
      .nxt (rnd_nxt[l])
    );
    assign digest[l*128 +: 128] = {chain_q[l].d, chain_q[l].c, chain_q[l].b, chain_q[l].a};
  end

  // Buffers only accept writes while idle and for an existing lane.
  assign wr_ok = (state_q == IDLE) && (int'(msg_lane) < LANES);

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    run_mask_d = run_mask_q;
    chain_d    = chain_q;
    work_d     = work_q;
    buf_d      = buf_q;
    msg_err_d  = msg_we && !wr_ok;
    if (msg_we && wr_ok) buf_d[msg_lane][msg_addr] = msg_data;

    case (state_q)
      IDLE: begin
        if (start && (|start_mask)) begin
          run_mask_d = start_mask;
          i_d        = '0;
          state_d    = CRUNCH;
          for (int l = 0; l < LANES; l++) begin
            if (start_mask[l]) begin
              if (init_mask[l]) chain_d[l] = IV;
              work_d[l] = init_mask[l] ? IV : chain_q[l];
            end
          end
        end
      end
      CRUNCH: begin
        for (int l = 0; l < LANES; l++)
          if (run_mask_q[l]) work_d[l] = rnd_nxt[l];
        i_d = i_q + 6'd1;
        if (i_q == 6'd63) state_d = FINAL;
      end
      FINAL: begin
        for (int l = 0; l < LANES; l++)
          if (run_mask_q[l])
            chain_d[l] = '{a: chain_q[l].a + work_q[l].a, b: chain_q[l].b + work_q[l].b,
                           c: chain_q[l].c + work_q[l].c, d: chain_q[l].d + work_q[l].d};
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      i_q        <= '0;
      run_mask_q <= '0;
      work_q     <= '0;
      msg_err_q  <= 1'b0;
      for (int l = 0; l < LANES; l++) chain_q[l] <= IV;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      run_mask_q <= run_mask_d;
      work_q     <= work_d;
      msg_err_q  <= msg_err_d;
      chain_q    <= chain_d;
    end
  end

  // Message buffers deliberately survive reset.
  always_ff @(posedge clk) buf_q <= buf_d;

  assign busy    = (state_q == CRUNCH) || (state_q == FINAL);
  assign done    = (state_q == DONE);
  assign msg_err = msg_err_q;

endmodule
